ap_ctrl_txn_profiler: RTL and testbench
=======================================

Name: ap_ctrl_txn_profiler

Overview:
- Synthesizable consumer of the block-level ap_ctrl_chain handshake (ap_start/ap_ready/ap_done/ap_continue) of an HLS kernel such as the MAC core.
- Measures per-transaction latency, start-to-start interval and output-stall cycles.
- Buffers one record per completed transaction in a small FIFO, drained over a valid/ready port by the CSV dump path or a debug bus.
- Same probe point the simulation dataflow monitor uses, but usable on hardware.

Parameters:
- CNT_W, 32: width of the latency, interval and stall counters; all saturate at 2^CNT_W-1.
- ID_W, 8: width of the transaction index; wraps modulo 2^ID_W.
- DEPTH, 4: record FIFO depth. Power of two, at least 2.

Ports:
- clock  in  1  single clock, all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- ap_start  in  1  kernel start, sampled
- ap_ready  in  1  kernel ready, sampled (informational; held as a per-txn flag)
- ap_done  in  1  kernel done, sampled
- ap_continue  in  1  downstream continue, sampled
- finish  in  1  end-of-run request
- rec_valid  out  1  FIFO head record valid
- rec_ready  in  1  consumer accepts head record
- rec_id  out  ID_W  transaction index of the head record
- rec_latency  out  CNT_W  cycles from start cycle to completion cycle, both inclusive
- rec_interval  out  CNT_W  cycles from the previous start cycle to this start cycle; 0 for the first transaction
- rec_stall  out  CNT_W  cycles with ap_done=1 and ap_continue=0
- overflow  out  1  sticky: a record was dropped because the FIFO was full
- busy  out  1  FSM not in IDLE
- flushed  out  1  finish seen, FSM in IDLE and FIFO empty

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, all counters 0, txn index 0, first-start flag cleared.
- Asserting reset mid-transaction discards the in-flight measurement and all buffered records.
- FSM states are IDLE, RUN and HOLD. A start cycle is any cycle where the FSM is IDLE, ap_start=1 and finish_seen=0.
- IDLE:
  - On a start cycle: go to RUN, latency<=1, stall<=0.
  - rec_interval is captured from the interval counter, or forced to 0 if this is the first start.
  - The interval counter restarts at 1.
- RUN: latency increments each cycle.
  - ap_done=1 and ap_continue=1: completion cycle, push record, txn index increments.
  - ap_done=1 and ap_continue=0: go to HOLD, stall<=1.
  - ap_done=0: stay in RUN.
- HOLD: latency increments each cycle.
  - ap_continue=0: stall increments.
  - ap_continue=1: completion cycle, push record, txn index increments.
- After a completion cycle:
  - If ap_start=1 and finish_seen=0 in that same cycle: treat it as a new start cycle and go to RUN. This is back-to-back; interval uses this cycle.
  - Otherwise go to IDLE.
- The interval counter runs every cycle after the first start and saturates. Latency and stall also saturate and never wrap.
- finish:
  - Sets finish_seen, which is sticky until reset.
  - After that, new starts are ignored; an in-flight transaction still completes and is recorded.
  - flushed=1 when finish_seen, FSM in IDLE and FIFO empty.
- FIFO:
  - rec_* outputs show the head entry; rec_valid equals not-empty.
  - Pop on rec_valid and rec_ready. A record pushed at a completion cycle is visible on rec_valid the next cycle.
  - Push and pop in the same cycle while full: both take effect, no drop.
  - Push while full with no pop: the record is dropped, overflow<=1 (sticky), and the txn index still increments.
- While rec_valid=1 and rec_ready=0, the rec_* outputs hold stable.

Test Plan:
- Single txn: ap_start high for 1 cycle, ap_done and ap_continue high 9 cycles later, rec_ready=1 -> one record: id=0, latency=10, interval=0, stall=0, rec_valid high for 1 cycle.
- Stall: ap_done high with ap_continue low for 3 cycles, then continue -> stall=3 and latency includes those 3 cycles.
- Back-to-back: completion cycle coincides with ap_start; second completion 5 cycles later -> second record id=1, interval equals the first latency, latency=6.
- Overflow: DEPTH=4, rec_ready=0, 5 txns complete -> 4 records held, overflow=1. Draining yields ids 0..3; a 6th txn is then recorded with id=5.
- Finish: finish asserted mid-RUN, ap_start held high afterwards -> in-flight record emitted, no new txn, flushed=1 after the drain.
- Async reset asserted in HOLD between clock edges -> outputs go to 0 immediately, FIFO empty, next txn gets id=0 and interval=0.

Source files
------------

// File: rtl/ap_ctrl_txn_profiler.sv
// Transaction profiler for an ap_ctrl_chain kernel: measures latency, start-to-start
// interval and output-stall cycles per transaction and queues one record per completion.
module ap_ctrl_txn_profiler #(
  parameter int CNT_W = 32,
  parameter int ID_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [ID_W-1:0]  rec_id,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_interval,
  output logic [CNT_W-1:0] rec_stall,
  output logic             overflow,
  output logic             busy,
  output logic             flushed
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] lat;
    logic [CNT_W-1:0] intv;
    logic [CNT_W-1:0] stall;
  } rec_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] latency_q, latency_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] interval_q, interval_d;
  logic [CNT_W-1:0] intv_cap_q, intv_cap_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             started_q, started_d;
  logic             finish_seen_q, finish_seen_d;
  logic             overflow_q, overflow_d;
  logic             ready_seen_q, ready_seen_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  rec_t             mem_q [DEPTH];
  rec_t             mem_d [DEPTH];

  logic             start_ok_s;
  logic             complete_s;
  logic             start_now_s;
  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  rec_t             rec_new_s;
  rec_t             head_s;
  logic             ready_unused_s;

  assign start_ok_s = ap_start & ~finish_seen_q;
  assign empty_s    = (wr_ptr_q == rd_ptr_q);
  assign full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_s      = ~empty_s & rec_ready;
  assign head_s     = mem_q[rd_ptr_q[AW-1:0]];
  // The per-transaction ap_ready flag is held for debug probing only.
  assign ready_unused_s = ready_seen_q;

  // Next-state logic for the FSM, measurement counters and record FIFO.
  always_comb begin
    state_d       = state_q;
    latency_d     = latency_q;
    stall_d       = stall_q;
    interval_d    = started_q ? sat_inc(interval_q) : interval_q;
    intv_cap_d    = intv_cap_q;
    id_d          = id_q;
    started_d     = started_q;
    finish_seen_d = finish_seen_q | finish;
    overflow_d    = overflow_q;
    ready_seen_d  = ready_seen_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mem_d         = mem_q;
    complete_s    = 1'b0;
    rec_new_s     = '{id: id_q, lat: sat_inc(latency_q), intv: intv_cap_q, stall: stall_q};

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      RUN: begin
        latency_d = sat_inc(latency_q);
        if (ap_done && ap_continue) begin
          complete_s = 1'b1;
        end else if (ap_done) begin
          state_d = HOLD;
          stall_d = CNT_W'(1);
        end else begin
          state_d = RUN;
        end
      end
      HOLD: begin
        latency_d = sat_inc(latency_q);
        if (ap_continue) begin
          complete_s = 1'b1;
        end else begin
          stall_d = sat_inc(stall_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (complete_s) begin
      state_d = IDLE;
      id_d    = id_q + ID_W'(1);
    end else begin
      id_d    = id_q;
    end

    if (state_q != IDLE) begin
      ready_seen_d = ready_seen_q | ap_ready;
    end else begin
      ready_seen_d = ready_seen_q;
    end

    // A completion cycle that also carries ap_start opens the next transaction.
    start_now_s = start_ok_s & ((state_q == IDLE) | complete_s);
    if (start_now_s) begin
      state_d      = RUN;
      latency_d    = CNT_W'(1);
      stall_d      = {CNT_W{1'b0}};
      intv_cap_d   = started_q ? sat_inc(interval_q) : {CNT_W{1'b0}};
      interval_d   = CNT_W'(1);
      started_d    = 1'b1;
      ready_seen_d = ap_ready;
    end else begin
      started_d    = started_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    if (complete_s && (!full_s || pop_s)) begin
      mem_d[wr_ptr_q[AW-1:0]] = rec_new_s;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end else if (complete_s) begin
      overflow_d = 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      latency_q     <= {CNT_W{1'b0}};
      stall_q       <= {CNT_W{1'b0}};
      interval_q    <= {CNT_W{1'b0}};
      intv_cap_q    <= {CNT_W{1'b0}};
      id_q          <= {ID_W{1'b0}};
      started_q     <= 1'b0;
      finish_seen_q <= 1'b0;
      overflow_q    <= 1'b0;
      ready_seen_q  <= 1'b0;
      wr_ptr_q      <= {(AW+1){1'b0}};
      rd_ptr_q      <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      latency_q     <= latency_d;
      stall_q       <= stall_d;
      interval_q    <= interval_d;
      intv_cap_q    <= intv_cap_d;
      id_q          <= id_d;
      started_q     <= started_d;
      finish_seen_q <= finish_seen_d;
      overflow_q    <= overflow_d;
      ready_seen_q  <= ready_seen_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Record fields read as zero whenever the FIFO is empty.
  assign rec_valid    = ~empty_s;
  assign rec_id       = empty_s ? {ID_W{1'b0}}  : head_s.id;
  assign rec_latency  = empty_s ? {CNT_W{1'b0}} : head_s.lat;
  assign rec_interval = empty_s ? {CNT_W{1'b0}} : head_s.intv;
  assign rec_stall    = empty_s ? {CNT_W{1'b0}} : head_s.stall;
  assign overflow     = overflow_q;
  assign busy         = (state_q != IDLE);
  assign flushed      = finish_seen_q & (state_q == IDLE) & empty_s;

endmodule

// File: tb/tb_ap_ctrl_txn_profiler.sv
// Self-checking bench for ap_ctrl_txn_profiler: directed scenarios plus a randomized
// run against a cycle-stamp reference model.
module tb_ap_ctrl_txn_profiler;
  localparam int CNT_W = 32;
  localparam int ID_W  = 8;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b0;
  logic             finish = 1'b0, rec_ready = 1'b0;
  logic             rec_valid, overflow, busy, flushed;
  logic [ID_W-1:0]  rec_id;
  logic [CNT_W-1:0] rec_latency, rec_interval, rec_stall;

  int checks = 0;
  int errors = 0;

  ap_ctrl_txn_profiler #(.CNT_W(CNT_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_id(rec_id),
    .rec_latency(rec_latency), .rec_interval(rec_interval), .rec_stall(rec_stall),
    .overflow(overflow), .busy(busy), .flushed(flushed)
  );

  always #5 clock = ~clock;

  // Reference model: transactions described by the cycle numbers of their starts.
  typedef struct {
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] lat;
    logic [CNT_W-1:0] intv;
    logic [CNT_W-1:0] stall;
  } mrec_t;

  mrec_t       mq[$];
  int          cyc, m_start, m_prev;
  bit          m_infl, m_dseen, m_fin, m_ovf;
  int unsigned m_intv, m_stall, m_id;

  task automatic model_reset();
    cyc = 0; m_start = 0; m_prev = -1;
    m_infl = 0; m_dseen = 0; m_fin = 0; m_ovf = 0;
    m_intv = 0; m_stall = 0; m_id = 0;
    mq.delete();
  endtask

  task automatic model_step();
    bit    pop, comp;
    mrec_t r;
    pop  = (mq.size() > 0) && rec_ready;
    comp = 0;
    if (m_infl) begin
      if (ap_done) m_dseen = 1;
      if (m_dseen) begin
        if (ap_continue) comp = 1;
        else m_stall++;
      end
    end
    if (comp) begin
      r.id    = m_id[ID_W-1:0];
      r.lat   = 32'(cyc - m_start + 1);
      r.intv  = m_intv;
      r.stall = m_stall;
      m_id++;
      m_infl = 0;
    end
    if (!m_infl && ap_start && !m_fin) begin
      m_intv  = (m_prev < 0) ? 0 : (cyc - m_prev + 1);
      m_prev  = cyc;
      m_start = cyc;
      m_infl  = 1;
      m_dseen = 0;
      m_stall = 0;
    end
    if (pop) void'(mq.pop_front());
    if (comp) begin
      if (mq.size() < DEPTH) mq.push_back(r);
      else m_ovf = 1;
    end
    if (finish) m_fin = 1;
    cyc++;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0; finish = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rec_ready = 0;
    reset = 1;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rec_valid, overflow, busy, flushed} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {rec_valid, overflow, busy, flushed});
    end
    checks++;
    if ({rec_id, rec_latency, rec_interval, rec_stall} !== '0) begin
      errors++; $display("FAIL reset_fields got id=%0d lat=%0d int=%0d stall=%0d want 0",
                         rec_id, rec_latency, rec_interval, rec_stall);
    end
  endtask

  task automatic test_single();
    do_reset();
    rec_ready = 1; ap_start = 1; tick(); ap_start = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    repeat (8) tick();
    ap_done = 1; ap_continue = 1; tick(); ap_done = 0; ap_continue = 0;
    checks++;
    if ({rec_valid, rec_id, rec_latency, rec_interval, rec_stall} !== {1'b1, 8'd0, 32'd10, 32'd0, 32'd0}) begin
      errors++; $display("FAIL single_rec got v=%b id=%0d lat=%0d int=%0d stall=%0d want v=1 id=0 lat=10 int=0 stall=0",
                         rec_valid, rec_id, rec_latency, rec_interval, rec_stall);
    end
    tick();
    checks++;
    if ({rec_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL single_drain got v=%b busy=%b want 0 0", rec_valid, busy);
    end
  endtask

  task automatic test_stall();
    do_reset();
    rec_ready = 0; ap_start = 1; tick(); ap_start = 0;
    repeat (4) tick();
    ap_done = 1; ap_continue = 0; repeat (3) tick();
    ap_continue = 1; tick(); ap_done = 0; ap_continue = 0;
    checks++;
    if ({rec_valid, rec_latency, rec_stall} !== {1'b1, 32'd9, 32'd3}) begin
      errors++; $display("FAIL stall_rec got v=%b lat=%0d stall=%0d want v=1 lat=9 stall=3",
                         rec_valid, rec_latency, rec_stall);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rec_ready = 0; ap_start = 1; tick(); ap_start = 0;
    repeat (8) tick();
    ap_start = 1; ap_done = 1; ap_continue = 1; tick();
    idle_inputs();
    repeat (4) tick();
    ap_done = 1; ap_continue = 1; tick(); idle_inputs();
    checks++;
    if ({rec_id, rec_latency, rec_interval} !== {8'd0, 32'd10, 32'd0}) begin
      errors++; $display("FAIL b2b_first got id=%0d lat=%0d int=%0d want 0 10 0", rec_id, rec_latency, rec_interval);
    end
    tick();
    checks++;
    if ({rec_valid, rec_id, rec_latency} !== {1'b1, 8'd0, 32'd10}) begin
      errors++; $display("FAIL b2b_hold got v=%b id=%0d lat=%0d want 1 0 10", rec_valid, rec_id, rec_latency);
    end
    rec_ready = 1; tick(); rec_ready = 0;
    checks++;
    if ({rec_valid, rec_id, rec_latency, rec_interval, rec_stall} !== {1'b1, 8'd1, 32'd6, 32'd10, 32'd0}) begin
      errors++; $display("FAIL b2b_second got v=%b id=%0d lat=%0d int=%0d stall=%0d want 1 1 6 10 0",
                         rec_valid, rec_id, rec_latency, rec_interval, rec_stall);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    rec_ready = 0;
    for (int t = 0; t < 5; t++) begin
      ap_start = 1; tick(); ap_start = 0;
      ap_done = 1; ap_continue = 1; tick(); ap_done = 0; ap_continue = 0;
      if (t == 3) begin
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
      end
    end
    checks++;
    if ({overflow, rec_valid} !== 2'b11) begin
      errors++; $display("FAIL ovf_set got ovf=%b v=%b want 1 1", overflow, rec_valid);
    end
    rec_ready = 1;
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if ({rec_valid, rec_id} !== {1'b1, 8'(k)}) begin
        errors++; $display("FAIL ovf_drain%0d got v=%b id=%0d want 1 %0d", k, rec_valid, rec_id, k);
      end
      tick();
    end
    rec_ready = 0;
    checks++;
    if ({rec_valid, overflow} !== 2'b01) begin
      errors++; $display("FAIL ovf_empty got v=%b ovf=%b want 0 1", rec_valid, overflow);
    end
    ap_start = 1; tick(); ap_start = 0;
    ap_done = 1; ap_continue = 1; tick(); ap_done = 0; ap_continue = 0;
    checks++;
    if ({rec_valid, rec_id} !== {1'b1, 8'd5}) begin
      errors++; $display("FAIL ovf_sixth got v=%b id=%0d want 1 5", rec_valid, rec_id);
    end
  endtask

  task automatic test_finish();
    do_reset();
    rec_ready = 0; ap_start = 1; tick(); ap_start = 0;
    repeat (2) tick();
    finish = 1; tick(); finish = 0;
    ap_start = 1;
    repeat (2) tick();
    ap_done = 1; ap_continue = 1; tick(); ap_done = 0; ap_continue = 0;
    tick();
    checks++;
    if ({busy, rec_valid, flushed, rec_id, rec_latency} !== {1'b0, 1'b1, 1'b0, 8'd0, 32'd7}) begin
      errors++; $display("FAIL finish_rec got busy=%b v=%b fl=%b id=%0d lat=%0d want 0 1 0 0 7",
                         busy, rec_valid, flushed, rec_id, rec_latency);
    end
    rec_ready = 1; tick();
    tick();
    checks++;
    if ({busy, rec_valid, flushed} !== 3'b001) begin
      errors++; $display("FAIL finish_flushed got busy=%b v=%b fl=%b want 0 0 1", busy, rec_valid, flushed);
    end
    ap_start = 0; rec_ready = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    rec_ready = 0; ap_start = 1; tick(); ap_start = 0;
    ap_done = 1; ap_continue = 1; tick();
    ap_done = 0; ap_continue = 0; ap_start = 1; tick(); ap_start = 0;
    tick();
    ap_done = 1; repeat (2) tick();
    checks++;
    if ({busy, rec_valid} !== 2'b11) begin
      errors++; $display("FAIL areset_pre got busy=%b v=%b want 1 1", busy, rec_valid);
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({rec_valid, overflow, busy, flushed, rec_id, rec_latency, rec_interval, rec_stall} !== '0) begin
      errors++; $display("FAIL areset_now got v=%b ovf=%b busy=%b fl=%b id=%0d lat=%0d want all 0",
                         rec_valid, overflow, busy, flushed, rec_id, rec_latency);
    end
    model_reset();
    idle_inputs();
    @(negedge clock);
    reset = 0;
    ap_start = 1; tick(); ap_start = 0;
    tick();
    ap_done = 1; ap_continue = 1; tick(); idle_inputs();
    checks++;
    if ({rec_valid, rec_id, rec_interval, rec_latency} !== {1'b1, 8'd0, 32'd0, 32'd3}) begin
      errors++; $display("FAIL areset_next got v=%b id=%0d int=%0d lat=%0d want 1 0 0 3",
                         rec_valid, rec_id, rec_interval, rec_latency);
    end
  endtask

  task automatic test_random();
    bit exp_fl;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      ap_start    = ($urandom_range(0, 99) < 35);
      ap_ready    = $urandom_range(0, 1);
      ap_done     = ($urandom_range(0, 99) < 30);
      ap_continue = ($urandom_range(0, 99) < 50);
      rec_ready   = ($urandom_range(0, 99) < 30);
      finish      = (i > 1700) && ($urandom_range(0, 99) < 3);
      tick();
      checks++;
      if (rec_valid !== (mq.size() > 0)) begin
        errors++; $display("FAIL rnd_valid cyc=%0d got %b want %b", i, rec_valid, (mq.size() > 0));
      end
      if (mq.size() > 0) begin
        checks++;
        if ({rec_id, rec_latency, rec_interval, rec_stall} !== {mq[0].id, mq[0].lat, mq[0].intv, mq[0].stall}) begin
          errors++; $display("FAIL rnd_rec cyc=%0d got id=%0d lat=%0d int=%0d stall=%0d want %0d %0d %0d %0d",
                             i, rec_id, rec_latency, rec_interval, rec_stall,
                             mq[0].id, mq[0].lat, mq[0].intv, mq[0].stall);
        end
      end
      exp_fl = m_fin && !m_infl && (mq.size() == 0);
      checks++;
      if ({overflow, busy, flushed} !== {m_ovf, m_infl, exp_fl}) begin
        errors++; $display("FAIL rnd_status cyc=%0d got ovf=%b busy=%b fl=%b want %b %b %b",
                           i, overflow, busy, flushed, m_ovf, m_infl, exp_fl);
      end
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_finish();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
